// File: rtl/asynch_edge_detect_bank_if.sv
// asynch_edge_detect_bank_if: channel inputs, mode/clear/select controls and status outputs of the edge detector bank
interface asynch_edge_detect_bank_if #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
);
  localparam int SEL_WIDTH = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic [CHANNELS-1:0]   ASYNC_IN;
  logic [2*CHANNELS-1:0] MODE_IN;
  logic [CHANNELS-1:0]   CLEAR_IN;
  logic [SEL_WIDTH-1:0]  COUNT_SEL_IN;
  logic [CHANNELS-1:0]   LEVEL_OUT;
  logic [CHANNELS-1:0]   DETECT_OUT;
  logic [CHANNELS-1:0]   PENDING_OUT;
  logic                  ANY_PENDING_OUT;
  logic [CNT_WIDTH-1:0]  COUNT_OUT;
  modport slave (
    input  ASYNC_IN, MODE_IN, CLEAR_IN, COUNT_SEL_IN,
    output LEVEL_OUT, DETECT_OUT, PENDING_OUT, ANY_PENDING_OUT, COUNT_OUT
  );
  modport master (
    output ASYNC_IN, MODE_IN, CLEAR_IN, COUNT_SEL_IN,
    input  LEVEL_OUT, DETECT_OUT, PENDING_OUT, ANY_PENDING_OUT, COUNT_OUT
  );
endinterface

// File: rtl/asynch_edge_detect_bank.sv
// asynch_edge_detect_bank: per-channel synchroniser, glitch filter, edge-mode detect, sticky pending flag and saturating counter
module asynch_edge_detect_bank #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int CNT_WIDTH     = 8,
  parameter bit INIT_LEVEL    = 1'b0
) (
  input logic SYNC_CLK_IN,
  input logic RESET_N_IN,
  asynch_edge_detect_bank_if.slave bus
);
  localparam int FW = FILTER_CYCLES > 0 ? $clog2(FILTER_CYCLES + 1) : 1;
  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][FW-1:0]          fcnt_q, fcnt_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  lvl_q, lvl_d, det_q, det_d, pend_q, pend_d, sl, acc;
  logic [CNT_WIDTH-1:0]                 cout_q, cout_d;

  always_comb begin
    {sl, acc, lvl_d, det_d, pend_d} = '0;
    sync_d = '0;
    fcnt_d = '0;
    cnt_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sl[i]     = sync_q[i][SYNC_STAGES-1];
      acc[i]    = sl[i] != lvl_q[i] && fcnt_q[i] == FW'(FILTER_CYCLES);
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], bus.ASYNC_IN[i]};
      fcnt_d[i] = (sl[i] == lvl_q[i] || acc[i]) ? '0 : fcnt_q[i] + 1'b1;
      lvl_d[i]  = acc[i] ? sl[i] : lvl_q[i];
      // new level 1 is a rise (mode bit 0), new level 0 a fall (mode bit 1)
      det_d[i]  = acc[i] & (sl[i] ? bus.MODE_IN[2*i] : bus.MODE_IN[2*i+1]);
      pend_d[i] = det_q[i] | (pend_q[i] & ~bus.CLEAR_IN[i]);
      cnt_d[i]  = bus.CLEAR_IN[i] ? CNT_WIDTH'(det_q[i]) :
                  (det_q[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i];
    end
    cout_d = 32'(bus.COUNT_SEL_IN) < CHANNELS ? cnt_q[bus.COUNT_SEL_IN] : '0;
  end

  always_ff @(posedge SYNC_CLK_IN or negedge RESET_N_IN)
    if (!RESET_N_IN) begin
      sync_q <= {CHANNELS*SYNC_STAGES{INIT_LEVEL}};
      fcnt_q <= '0;
      lvl_q  <= {CHANNELS{INIT_LEVEL}};
      det_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      cout_q <= '0;
    end else begin
      sync_q <= sync_d;
      fcnt_q <= fcnt_d;
      lvl_q  <= lvl_d;
      det_q  <= det_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      cout_q <= cout_d;
    end

  assign bus.LEVEL_OUT       = lvl_q;
  assign bus.DETECT_OUT      = det_q;
  assign bus.PENDING_OUT     = pend_q;
  assign bus.ANY_PENDING_OUT = |pend_q;
  assign bus.COUNT_OUT       = cout_q;
endmodule

// File: tb/tb_asynch_edge_detect_bank.sv
// tb_asynch_edge_detect_bank: three differently parametrised banks; bank b is checked every cycle against a sliding-window model
module tb_asynch_edge_detect_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  asynch_edge_detect_bank_if #(.CHANNELS(4), .CNT_WIDTH(8)) ifa ();
  asynch_edge_detect_bank_if #(.CHANNELS(4), .CNT_WIDTH(3)) ifb ();
  asynch_edge_detect_bank_if #(.CHANNELS(3), .CNT_WIDTH(8)) ifc ();

  asynch_edge_detect_bank dut_a (.SYNC_CLK_IN(clk), .RESET_N_IN(rst_n), .bus(ifa));
  asynch_edge_detect_bank #(.CHANNELS(4), .FILTER_CYCLES(3), .CNT_WIDTH(3)) dut_b (
    .SYNC_CLK_IN(clk), .RESET_N_IN(rst_n), .bus(ifb));
  asynch_edge_detect_bank #(.CHANNELS(3), .FILTER_CYCLES(4)) dut_c (
    .SYNC_CLK_IN(clk), .RESET_N_IN(rst_n), .bus(ifc));

  // reference for bank b: 2 sync stages, filter window of 4 samples, 3-bit counter
  localparam int B_SYNC = 2;
  localparam int B_WIN  = 4;
  localparam int B_MAX  = 7;
  logic [3:0] m_lvl, m_det, m_pend;
  int m_cnt[4];
  int m_cout;
  bit m_smp[4][$];
  bit m_sq[4][$];

  task automatic model_reset();
    m_lvl = '0;
    m_det = '0;
    m_pend = '0;
    m_cout = 0;
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = 0;
      m_smp[c].delete();
      m_sq[c].delete();
    end
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [7:0] md, input logic [3:0] clr, input logic [1:0] sel);
    logic [3:0] nd;
    bit s, ok;
    nd = '0;
    m_cout = m_cnt[sel];
    for (int c = 0; c < 4; c++) begin
      if (m_det[c]) m_pend[c] = 1'b1;
      else if (clr[c]) m_pend[c] = 1'b0;
      if (clr[c]) m_cnt[c] = int'(m_det[c]);
      else if (m_det[c] && m_cnt[c] < B_MAX) m_cnt[c] = m_cnt[c] + 1;
      s = (m_smp[c].size() >= B_SYNC) ? m_smp[c][m_smp[c].size()-B_SYNC] : 1'b0;
      m_sq[c].push_back(s);
      if (m_sq[c].size() > B_WIN) void'(m_sq[c].pop_front());
      ok = m_sq[c].size() == B_WIN;
      for (int k = 0; k < m_sq[c].size(); k++) if (m_sq[c][k] == m_lvl[c]) ok = 1'b0;
      nd[c] = ok && ((s && md[2*c]) || (!s && md[2*c+1]));
      if (ok) m_lvl[c] = s;
      m_smp[c].push_back(a[c]);
      if (m_smp[c].size() > B_SYNC) void'(m_smp[c].pop_front());
    end
    m_det = nd;
  endtask

  task automatic tick();
    logic [3:0] a, clr;
    logic [7:0] md;
    logic [1:0] sel;
    if (!rst_n) model_reset();
    a = ifb.ASYNC_IN;
    md = ifb.MODE_IN;
    clr = ifb.CLEAR_IN;
    sel = ifb.COUNT_SEL_IN;
    @(posedge clk);
    if (rst_n) model_edge(a, md, clr, sel);
    #1;
    total++; if (ifb.LEVEL_OUT !== m_lvl) begin bad++; $display("FAIL b_level t=%0t got=%h exp=%h", $time, ifb.LEVEL_OUT, m_lvl); end
    total++; if (ifb.DETECT_OUT !== m_det) begin bad++; $display("FAIL b_detect t=%0t got=%h exp=%h", $time, ifb.DETECT_OUT, m_det); end
    total++; if (ifb.PENDING_OUT !== m_pend) begin bad++; $display("FAIL b_pending t=%0t got=%h exp=%h", $time, ifb.PENDING_OUT, m_pend); end
    total++; if (ifb.ANY_PENDING_OUT !== (|m_pend)) begin bad++; $display("FAIL b_any t=%0t got=%b exp=%b", $time, ifb.ANY_PENDING_OUT, |m_pend); end
    total++; if (ifb.COUNT_OUT !== 3'(m_cout)) begin bad++; $display("FAIL b_count t=%0t got=%0d exp=%0d", $time, ifb.COUNT_OUT, m_cout); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ifa.ASYNC_IN = 4'hF; ifa.MODE_IN = 8'h55; ifa.CLEAR_IN = '0; ifa.COUNT_SEL_IN = '0;
    ifb.ASYNC_IN = '0; ifb.MODE_IN = '0; ifb.CLEAR_IN = '0; ifb.COUNT_SEL_IN = '0;
    ifc.ASYNC_IN = '0; ifc.MODE_IN = '0; ifc.CLEAR_IN = '0; ifc.COUNT_SEL_IN = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (ifa.LEVEL_OUT !== 4'h0) begin bad++; $display("FAIL rst_level got=%h exp=0", ifa.LEVEL_OUT); end
    total++; if (ifa.DETECT_OUT !== 4'h0) begin bad++; $display("FAIL rst_detect got=%h exp=0", ifa.DETECT_OUT); end
    total++; if (ifa.PENDING_OUT !== 4'h0 || ifa.ANY_PENDING_OUT !== 1'b0) begin bad++; $display("FAIL rst_pending got=%h/%b exp=0/0", ifa.PENDING_OUT, ifa.ANY_PENDING_OUT); end
    total++; if (ifa.COUNT_OUT !== 8'h0) begin bad++; $display("FAIL rst_count got=%0d exp=0", ifa.COUNT_OUT); end
    rst_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      total++; if (ifa.DETECT_OUT !== (k == 2 ? 4'hF : 4'h0)) begin bad++; $display("FAIL rel_detect k=%0d got=%h exp=%h", k, ifa.DETECT_OUT, k == 2 ? 4'hF : 4'h0); end
    end
    total++; if (ifa.PENDING_OUT !== 4'hF) begin bad++; $display("FAIL rel_pending got=%h exp=F", ifa.PENDING_OUT); end
    total++; if (ifa.COUNT_OUT !== 8'd1) begin bad++; $display("FAIL rel_count got=%0d exp=1", ifa.COUNT_OUT); end
  endtask

  task automatic test_rising();
    ifa.ASYNC_IN = '0; ifa.MODE_IN = 8'h01; ifa.COUNT_SEL_IN = '0;
    do_reset();
    repeat (3) tick();
    ifa.ASYNC_IN[0] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      total++; if (ifa.DETECT_OUT[0] !== (k == 2)) begin bad++; $display("FAIL rise_detect k=%0d got=%b exp=%b", k, ifa.DETECT_OUT[0], k == 2); end
      if (k == 3) begin
        total++; if (ifa.PENDING_OUT[0] !== 1'b1 || ifa.ANY_PENDING_OUT !== 1'b1) begin bad++; $display("FAIL rise_pending got=%b/%b exp=1/1", ifa.PENDING_OUT[0], ifa.ANY_PENDING_OUT); end
      end
    end
    total++; if (ifa.COUNT_OUT !== 8'd1) begin bad++; $display("FAIL rise_count got=%0d exp=1", ifa.COUNT_OUT); end
    total++; if (ifa.LEVEL_OUT !== 4'h1) begin bad++; $display("FAIL rise_level got=%h exp=1", ifa.LEVEL_OUT); end
  endtask

  task automatic test_modes();
    int seen;
    ifa.MODE_IN = 8'h09;
    seen = 0;
    ifa.ASYNC_IN[1] = 1'b1;
    repeat (5) begin tick(); seen += int'(ifa.DETECT_OUT[1]); end
    total++; if (seen != 0 || ifa.LEVEL_OUT[1] !== 1'b1) begin bad++; $display("FAIL mode10_rise detects=%0d level=%b exp 0/1", seen, ifa.LEVEL_OUT[1]); end
    seen = 0;
    ifa.ASYNC_IN[1] = 1'b0;
    repeat (5) begin tick(); seen += int'(ifa.DETECT_OUT[1]); end
    total++; if (seen != 1 || ifa.LEVEL_OUT[1] !== 1'b0) begin bad++; $display("FAIL mode10_fall detects=%0d level=%b exp 1/0", seen, ifa.LEVEL_OUT[1]); end
    seen = 0;
    ifa.ASYNC_IN[2] = 1'b1;
    repeat (5) begin tick(); seen += int'(ifa.DETECT_OUT[2]); end
    total++; if (ifa.LEVEL_OUT[2] !== 1'b1) begin bad++; $display("FAIL mode00_level_hi got=%b exp=1", ifa.LEVEL_OUT[2]); end
    ifa.ASYNC_IN[2] = 1'b0;
    ifa.COUNT_SEL_IN = 2'd2;
    repeat (5) begin tick(); seen += int'(ifa.DETECT_OUT[2]); end
    total++; if (ifa.LEVEL_OUT[2] !== 1'b0) begin bad++; $display("FAIL mode00_level_lo got=%b exp=0", ifa.LEVEL_OUT[2]); end
    total++; if (seen != 0 || ifa.COUNT_OUT !== 8'd0 || ifa.PENDING_OUT[2] !== 1'b0) begin bad++; $display("FAIL mode00_count detects=%0d count=%0d pend=%b exp 0/0/0", seen, ifa.COUNT_OUT, ifa.PENDING_OUT[2]); end
  endtask

  task automatic test_clear();
    ifa.MODE_IN = 8'h0D;
    ifa.ASYNC_IN[1] = 1'b1;
    repeat (3) tick();
    total++; if (ifa.DETECT_OUT[1] !== 1'b1) begin bad++; $display("FAIL clr_detect got=%b exp=1", ifa.DETECT_OUT[1]); end
    ifa.CLEAR_IN[1] = 1'b1;
    tick();
    ifa.CLEAR_IN = '0;
    total++; if (ifa.PENDING_OUT[1] !== 1'b1) begin bad++; $display("FAIL clr_pending got=%b exp=1", ifa.PENDING_OUT[1]); end
    ifa.COUNT_SEL_IN = 2'd1;
    tick();
    total++; if (ifa.COUNT_OUT !== 8'd1) begin bad++; $display("FAIL clr_count got=%0d exp=1", ifa.COUNT_OUT); end
  endtask

  task automatic test_glitch();
    int seen;
    ifb.MODE_IN = 8'hFF; ifb.ASYNC_IN = '0; ifb.CLEAR_IN = '0; ifb.COUNT_SEL_IN = '0;
    do_reset();
    repeat (3) tick();
    seen = 0;
    ifb.ASYNC_IN[0] = 1'b1;
    repeat (3) begin tick(); seen += int'(ifb.DETECT_OUT[0]); end
    ifb.ASYNC_IN[0] = 1'b0;
    repeat (10) begin tick(); seen += int'(ifb.DETECT_OUT[0]); end
    total++; if (seen != 0 || ifb.LEVEL_OUT[0] !== 1'b0) begin bad++; $display("FAIL glitch3 detects=%0d level=%b exp 0/0", seen, ifb.LEVEL_OUT[0]); end
    ifb.ASYNC_IN[0] = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      if (k == 6) ifb.ASYNC_IN[0] = 1'b0;
      tick();
      total++; if (ifb.DETECT_OUT[0] !== (k == 5 || k == 11)) begin bad++; $display("FAIL glitch6_detect k=%0d got=%b exp=%b", k, ifb.DETECT_OUT[0], k == 5 || k == 11); end
    end
    total++; if (ifb.COUNT_OUT !== 3'd2) begin bad++; $display("FAIL glitch6_count got=%0d exp=2", ifb.COUNT_OUT); end
  endtask

  task automatic test_saturation();
    ifb.CLEAR_IN = 4'hF;
    tick();
    ifb.CLEAR_IN = '0;
    for (int n = 0; n < 9; n++) begin
      ifb.ASYNC_IN[1] = ~ifb.ASYNC_IN[1];
      repeat (8) tick();
    end
    ifb.COUNT_SEL_IN = 2'd1;
    repeat (2) tick();
    total++; if (ifb.COUNT_OUT !== 3'd7) begin bad++; $display("FAIL sat_count got=%0d exp=7", ifb.COUNT_OUT); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) ifb.MODE_IN = 8'($urandom);
      for (int c = 0; c < 4; c++) if ($urandom_range(4) == 0) ifb.ASYNC_IN[c] = ~ifb.ASYNC_IN[c];
      ifb.CLEAR_IN = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      ifb.COUNT_SEL_IN = 2'($urandom);
      tick();
    end
    ifb.CLEAR_IN = '0;
  endtask

  task automatic test_sel_range();
    ifc.MODE_IN = 6'h3F; ifc.COUNT_SEL_IN = 2'd0; ifc.ASYNC_IN = 3'b001;
    for (int k = 0; k <= 8; k++) begin
      tick();
      total++; if (ifc.DETECT_OUT[0] !== (k == 6)) begin bad++; $display("FAIL c_detect k=%0d got=%b exp=%b", k, ifc.DETECT_OUT[0], k == 6); end
    end
    total++; if (ifc.COUNT_OUT !== 8'd1) begin bad++; $display("FAIL c_count got=%0d exp=1", ifc.COUNT_OUT); end
    ifc.COUNT_SEL_IN = 2'd3;
    tick();
    total++; if (ifc.COUNT_OUT !== 8'd0) begin bad++; $display("FAIL sel_range got=%0d exp=0", ifc.COUNT_OUT); end
    ifc.COUNT_SEL_IN = 2'd0;
    tick();
    total++; if (ifc.COUNT_OUT !== 8'd1) begin bad++; $display("FAIL sel_back got=%0d exp=1", ifc.COUNT_OUT); end
  endtask

  task automatic test_reset_mid();
    int seen;
    ifc.ASYNC_IN = 3'b011;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (ifc.DETECT_OUT[1] !== 1'b0) begin bad++; $display("FAIL mid_pre_detect k=%0d got=%b exp=0", k, ifc.DETECT_OUT[1]); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ifc.LEVEL_OUT !== 3'b000) begin bad++; $display("FAIL mid_async_level got=%b exp=000", ifc.LEVEL_OUT); end
    total++; if (ifc.PENDING_OUT !== 3'b000 || ifc.DETECT_OUT !== 3'b000) begin bad++; $display("FAIL mid_async_flags pend=%b det=%b exp 000/000", ifc.PENDING_OUT, ifc.DETECT_OUT); end
    total++; if (ifc.COUNT_OUT !== 8'd0) begin bad++; $display("FAIL mid_async_count got=%0d exp=0", ifc.COUNT_OUT); end
    ifc.ASYNC_IN = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin tick(); seen += int'(|ifc.DETECT_OUT); end
    total++; if (seen != 0 || ifc.LEVEL_OUT !== 3'b000) begin bad++; $display("FAIL mid_post detects=%0d level=%b exp 0/000", seen, ifc.LEVEL_OUT); end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_modes();
    test_clear();
    test_glitch();
    test_saturation();
    test_random();
    test_sel_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/asynch_edge_detect_bank.md
# asynch_edge_detect_bank

Multi-channel, parametrised edge detector for asynchronous inputs such as GPS PPS, front-end status lines and bridge handshakes. Each channel has a configurable synchroniser chain, a glitch filter and per-channel edge-mode selection. Each channel produces a one-cycle detect strobe, a sticky pending flag and a saturating event counter. It sits at the bridge boundary and feeds the interrupt/status logic in the `SYNC_CLK_IN` domain.

## Interface
- `CHANNELS`, default 4: number of independent input channels (1..32).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (>= 2).
- `FILTER_CYCLES`, default 0: extra cycles a new level must persist before acceptance. 0 means no filtering.
- `CNT_WIDTH`, default 8: width of each per-channel event counter.
- `INIT_LEVEL`, default 0: reset value of every synchroniser flop and accepted level.
- `SYNC_CLK_IN` in 1: the only clock; all logic is on its rising edge.
- `RESET_N_IN` in 1: asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to `SYNC_CLK_IN` upstream.
- `ASYNC_IN` in `CHANNELS`: asynchronous inputs, one bit per channel.
- `MODE_IN` in `2*CHANNELS`: bits [2i+1:2i] set the mode of channel i. 00 = off, 01 = rising, 10 = falling, 11 = both.
- `CLEAR_IN` in `CHANNELS`: synchronous one-cycle clear of pending flag and counter, per channel.
- `COUNT_SEL_IN` in `clog2(CHANNELS)` (min 1): selects which channel's counter drives `COUNT_OUT`.
- `LEVEL_OUT` out `CHANNELS`: accepted (synchronised and filtered) level per channel.
- `DETECT_OUT` out `CHANNELS`: registered one-cycle strobe per qualifying edge.
- `PENDING_OUT` out `CHANNELS`: sticky flag, set by a detect and cleared by `CLEAR_IN`.
- `ANY_PENDING_OUT` out 1: OR of `PENDING_OUT`.
- `COUNT_OUT` out `CNT_WIDTH`: registered counter value of the selected channel.

## Operation
- **Per-channel pipeline:** synchroniser `s[0..SYNC_STAGES-1]`, then the filter counter `fcnt` (width `clog2(FILTER_CYCLES+1)`, min 1), then the accepted level `lvl`.
- **Filter step, evaluated each cycle:**
  - If `s[last] == lvl`: `fcnt <= 0`.
  - Else if `fcnt == FILTER_CYCLES`: `lvl <= s[last]`, `fcnt <= 0`, and an accept event occurs.
  - Otherwise: `fcnt <= fcnt + 1`.
- **Glitch rejection:** a synchronised level that differs from `lvl` for fewer than `FILTER_CYCLES+1` consecutive cycles is discarded without trace.
- **Accept event:** an accept is a rise if the new `lvl` is 1 and a fall if it is 0.
- **Detect qualification:**
  - `DETECT_OUT[i] <= accept & ((rise & MODE[0]) | (fall & MODE[1]))`.
  - `MODE_IN` is sampled in the accept cycle only; it has no retroactive effect.
  - In mode off, `LEVEL_OUT` still tracks the input.
- **Pending flag:** set by a detect and cleared by `CLEAR_IN`. If both occur in the same cycle, set wins and `PENDING_OUT` stays 1.
- **Counter:** increments on each detect and saturates at `2^CNT_WIDTH-1`. Clear plus detect in the same cycle loads 1.
- **COUNT_OUT:** `<= cnt[COUNT_SEL_IN]`. A `COUNT_SEL_IN` at or above `CHANNELS` reads 0.
- **Reset values:**
  - `s` and `lvl` = `INIT_LEVEL`.
  - `fcnt`, `DETECT_OUT`, `PENDING_OUT`, counters and `COUNT_OUT` = 0.
  - `LEVEL_OUT` = `INIT_LEVEL`.
- **Input differing from INIT_LEVEL at reset release:** produces one accept event, which is a detect if the mode qualifies.
- **Reset mid-operation:** aborts any partially filtered transition; no detect is produced.

## Timing
- Let E0 be the first clock edge at which `s[0]` captures a new stable level.
- `lvl`, `LEVEL_OUT` and `DETECT_OUT` update at edge E(`SYNC_STAGES`+`FILTER_CYCLES`).
- `DETECT_OUT` is high for exactly one cycle.
- `PENDING_OUT` and the counter update one edge after `DETECT_OUT` rises.
- `COUNT_OUT` follows one more edge later. `COUNT_OUT` lags `COUNT_SEL_IN` by one edge.
- Minimum accepted pulse width at the synchroniser output is `FILTER_CYCLES+1` cycles.
- Back-to-back accepts on one channel are spaced at least `FILTER_CYCLES+1` cycles apart.
- Channels are fully independent; simultaneous events on all channels are all captured.

## Test plan
- **Reset:** hold `RESET_N_IN`=0 with `ASYNC_IN`=4'hF and clocks running.
  - Required: all outputs at reset values, `LEVEL_OUT`=0.
  - After release with `MODE_IN`=8'h55: `DETECT_OUT`=4'hF for one cycle at edge E2 (`SYNC_STAGES`=2, `FILTER_CYCLES`=0).
- **Rising edge, channel 0:** defaults, mode 01, `ASYNC_IN[0]` 0→1 before E0.
  - Required: `DETECT_OUT[0]` high only in the cycle after E2.
  - `PENDING_OUT[0]`=1 and `ANY_PENDING_OUT`=1 from E3.
  - `COUNT_OUT`=1 at E4 with `COUNT_SEL_IN`=0.
- **Glitch filter:** `FILTER_CYCLES`=3, mode 11.
  - A 3-cycle high pulse produces no detect and leaves `LEVEL_OUT` unchanged.
  - A 6-cycle high pulse produces a rise detect at E5 and a fall detect 6 cycles later; the counter reads 2.
- **Modes:**
  - Mode 10 with a rising edge: no detect, `LEVEL_OUT` goes to 1.
  - Mode 10 with the following falling edge: one detect.
  - Mode 00 with any edge: `LEVEL_OUT` toggles and the counter stays 0.
- **Clear and saturation:**
  - `CLEAR_IN[1]` in the same cycle as a detect on channel 1: `PENDING_OUT[1]` stays 1 and the counter reads 1.
  - `CNT_WIDTH`=3 with 9 detects: the counter reads 7.
  - `COUNT_SEL_IN` out of range: `COUNT_OUT` reads 0.
- **Reset mid-filter:** `FILTER_CYCLES`=4; assert `RESET_N_IN` 2 cycles into a transition.
  - Required: outputs clear immediately (asynchronously) and no detect is seen before or after release with the input returned low.
